mem_bus_router: RTL and testbench
=================================

# mem_bus_router

Routes each CPU load/store to either the RAM or the IO space using the select lines produced by the address decoder, tracks one outstanding transaction, and returns a single-cycle acknowledge with read data. It sits between the CPU memory port and the RAM/IO targets. It turns the decoder's combinational decision into a sequenced bus transaction. It supports fixed-latency RAM, ready-handshaked IO with a timeout, and error responses for unmapped addresses.

## Interface
- RAM_LATENCY, 1: RAM read-data latency in cycles after the `ram_req_o` cycle; legal range ≥1.
- IO_TIMEOUT, 255: maximum number of cycles `io_req_o` stays high without `io_ready_i`; legal range ≥1.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cpu_req_i  in  1  request valid; CPU holds it and all `cpu_*` fields stable until `cpu_ack_o`.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  30  word address.
- cpu_wdata_i  in  32  store data.
- cpu_be_i  in  4  byte enables.
- cpu_rdata_o  out  32  load data; valid only while `cpu_ack_o` is high.
- cpu_ack_o  out  1  one-cycle transaction-complete pulse.
- cpu_err_o  out  1  qualifies `cpu_ack_o`; signals an unmapped address or an IO timeout.
- dec_addr_o  out  30  address sent to the decoder.
- ram_select_i  in  1  decoder RAM hit.
- io_select_i  in  1  decoder IO hit.
- ram_req_o, ram_we_o  out  1 each  one-cycle RAM command.
- ram_addr_o  out  26  `addr[25:0]`.
- ram_wdata_o / ram_be_o  out  32 / 4  store data and byte enables.
- ram_rdata_i  in  32  RAM read data.
- io_req_o, io_we_o  out  1 each  IO command; `io_req_o` is held until ready or timeout.
- io_addr_o  out  14  `addr[13:0]`.
- io_wdata_o / io_be_o  out  32 / 4  store data and byte enables.
- io_rdata_i  in  32  IO read data.
- io_ready_i  in  1  IO completion; sampled while `io_req_o` is high.

## Operation
- States: IDLE, RAM_CMD, RAM_WAIT, IO_WAIT, RESP.
- `dec_addr_o` equals `cpu_addr_i` in IDLE and the latched address in all other states.
- IDLE with `cpu_req_i` = 1:
  - Latch we, addr, wdata and be.
  - If `ram_select_i` is 1, go to RAM_CMD. RAM has priority if both selects are high.
  - Else if `io_select_i` is 1, go to IO_WAIT and load the timeout counter with 0.
  - Else go to RESP with err = 1 and rdata = 0.
- RAM_CMD: `ram_req_o` = 1 for exactly this cycle.
  - Store: go to RESP.
  - Load: go to RAM_WAIT with the latency counter set to RAM_LATENCY−1.
- RAM_WAIT: count down; when the counter is 0, register `ram_rdata_i` and go to RESP.
- IO_WAIT: `io_req_o` = 1.
  - If `io_ready_i` is 1, register `io_rdata_i` (loads only; stores give rdata 0) and go to RESP with err = 0.
  - Else if the counter equals IO_TIMEOUT−1, go to RESP with err = 1 and rdata = 0.
  - Else increment the counter.
- RESP: `cpu_ack_o` = 1 for one cycle, with `cpu_err_o` and `cpu_rdata_o` taken from the registered values; then go to IDLE.
- `cpu_rdata_o` and `cpu_err_o` are 0 whenever `cpu_ack_o` is 0.
- A request present in the cycle after RESP is a new transaction. The CPU must drop or change its request after the ack.
- Command fields (`ram_*`, `io_*`) are driven from the latched registers; the `*_req_o` lines are registered state decodes.
- Counter width is `$clog2(IO_TIMEOUT+1)`; it never wraps.

## Timing
- Reset: state goes to IDLE. All outputs are 0 except `dec_addr_o`, which follows `cpu_addr_i`.
- Reset in mid-transaction abandons the transaction:
  - No ack is issued.
  - `io_req_o` and `ram_req_o` are low from the cycle after reset is sampled.
- Request accepted in IDLE at cycle 0:
  - Unmapped address: ack + err at cycle 1.
  - RAM store: `ram_req_o` at cycle 1, ack at cycle 2.
  - RAM load: `ram_req_o` at cycle 1; `ram_rdata_i` sampled at cycle 1+RAM_LATENCY; ack at cycle 2+RAM_LATENCY.
  - IO: `io_req_o` high from cycle 1. If `io_ready_i` is first high at cycle k, ack is at k+1 and `io_req_o` is low from k+1. Minimum latency is ack at cycle 2.
  - IO timeout: `io_req_o` high for cycles 1..IO_TIMEOUT; ack + err at cycle IO_TIMEOUT+1.
- Ready arriving on the final timeout cycle counts as success, not an error.
- Back-to-back requests: the next request is accepted one cycle after the ack.

## Test plan
- Reset then idle: `rst` held high for 3 cycles with `cpu_req_i` = 1 → no `ram_req_o`, `io_req_o` or ack during reset. After release, the request is accepted from IDLE.
- RAM load with RAM_LATENCY = 1: addr 0x0000123, model returns 0xDEADBEEF → `ram_req_o` at cycle 1 with `ram_addr_o` = 0x0000123, ack at cycle 3, rdata = 0xDEADBEEF, err = 0.
- RAM store: addr 0x10, wdata 0xA5A5A5A5, be 0x3 → a single `ram_req_o` pulse with we = 1, be = 0x3, wdata 0xA5A5A5A5; ack at cycle 2.
- IO load: addr 0x3C000005, `io_ready_i` asserted 4 cycles after `io_req_o` rises, rdata 0x00000042 → `io_addr_o` = 0x0005, ack at cycle 6, rdata = 0x42.
- IO timeout with IO_TIMEOUT = 8 and `io_ready_i` held at 0 → `io_req_o` high exactly 8 cycles, ack + err at cycle 9, rdata = 0.
- Unmapped address 0x20000000 → ack + err at cycle 1, no RAM or IO request. A back-to-back RAM load follows and is accepted at cycle 2.

Source files
------------

// File: rtl/mem_bus_router.sv
// Routes one CPU load/store at a time to fixed-latency RAM or ready-handshaked IO, or errors it.
// Ack after 1 (unmapped), 2 (RAM store), 2+RAM_LATENCY (RAM load) or ready+1 / IO_TIMEOUT+1 cycles; the CPU holds its request until the ack.
module mem_bus_router #(
  parameter int unsigned RAM_LATENCY = 1,
  parameter int unsigned IO_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [29:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_be_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ack_o,
  output logic        cpu_err_o,
  output logic [29:0] dec_addr_o,
  input  logic        ram_select_i,
  input  logic        io_select_i,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [25:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_be_o,
  input  logic [31:0] ram_rdata_i,
  output logic        io_req_o,
  output logic        io_we_o,
  output logic [13:0] io_addr_o,
  output logic [31:0] io_wdata_o,
  output logic [3:0]  io_be_o,
  input  logic [31:0] io_rdata_i,
  input  logic        io_ready_i
);

  localparam int unsigned CW = $clog2(IO_TIMEOUT + 1);
  localparam int unsigned LW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'(RAM_LATENCY - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(IO_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAM_CMD,
    S_RAM_WAIT,
    S_IO_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_we;
  logic [29:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;
  logic [CW-1:0]   r_cnt;
  logic [LW-1:0]   r_lat;
  logic [31:0]     r_rdata;
  logic            r_err;

  logic            w_accept;
  logic            w_unmapped;
  logic            w_lat_load;
  logic            w_lat_dec;
  logic            w_cap_ram;
  logic            w_cap_io;
  logic            w_timeout;
  logic            w_cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_unmapped  = 1'b0;
    w_lat_load  = 1'b0;
    w_lat_dec   = 1'b0;
    w_cap_ram   = 1'b0;
    w_cap_io    = 1'b0;
    w_timeout   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req_i) begin
          w_accept = 1'b1;
          // RAM wins when the decoder flags both targets
          if (ram_select_i) begin
            w_state_nxt = S_RAM_CMD;
          end else if (io_select_i) begin
            w_state_nxt = S_IO_WAIT;
          end else begin
            w_unmapped  = 1'b1;
            w_state_nxt = S_RESP;
          end
        end
      end
      S_RAM_CMD: begin
        if (r_we) begin
          w_state_nxt = S_RESP;
        end else begin
          w_lat_load  = 1'b1;
          w_state_nxt = S_RAM_WAIT;
        end
      end
      S_RAM_WAIT: begin
        if (r_lat == '0) begin
          w_cap_ram   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_lat_dec = 1'b1;
        end
      end
      S_IO_WAIT: begin
        // ready on the last allowed cycle still counts as success
        if (io_ready_i) begin
          w_cap_io    = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_cnt == TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
      r_lat   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= cpu_we_i;
        r_addr  <= cpu_addr_i;
        r_wdata <= cpu_wdata_i;
        r_be    <= cpu_be_i;
        r_cnt   <= '0;
        r_rdata <= '0;
        r_err   <= w_unmapped;
      end
      if (w_lat_load) begin
        r_lat <= LAT_INIT;
      end else if (w_lat_dec) begin
        r_lat <= r_lat - LW'(1);
      end
      if (w_cnt_inc) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_cap_ram) begin
        r_rdata <= ram_rdata_i;
      end
      if (w_cap_io) begin
        r_rdata <= r_we ? 32'h0 : io_rdata_i;
        r_err   <= 1'b0;
      end
      if (w_timeout) begin
        r_rdata <= 32'h0;
        r_err   <= 1'b1;
      end
    end
  end

  assign cpu_ack_o   = (r_state == S_RESP);
  assign cpu_rdata_o = cpu_ack_o ? r_rdata : 32'h0;
  assign cpu_err_o   = cpu_ack_o & r_err;
  assign dec_addr_o  = (r_state == S_IDLE) ? cpu_addr_i : r_addr;

  assign ram_req_o   = (r_state == S_RAM_CMD);
  assign ram_we_o    = r_we;
  assign ram_addr_o  = r_addr[25:0];
  assign ram_wdata_o = r_wdata;
  assign ram_be_o    = r_be;

  assign io_req_o    = (r_state == S_IO_WAIT);
  assign io_we_o     = r_we;
  assign io_addr_o   = r_addr[13:0];
  assign io_wdata_o  = r_wdata;
  assign io_be_o     = r_be;

endmodule

// File: tb/tb_mem_bus_router.sv
// Bench for mem_bus_router: directed cases with literal latencies plus a randomized run
// checked every cycle against a timeline model built from the transaction timing rules.
module tb_mem_bus_router;

  localparam int TB_RL = 1;
  localparam int TB_TO = 8;

  logic        clk;
  logic        rst;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [29:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [3:0]  cpu_be_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_ack_o;
  logic        cpu_err_o;
  logic [29:0] dec_addr_o;
  logic        ram_select_i;
  logic        io_select_i;
  logic        ram_req_o;
  logic        ram_we_o;
  logic [25:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_rdata_i;
  logic        io_req_o;
  logic        io_we_o;
  logic [13:0] io_addr_o;
  logic [31:0] io_wdata_o;
  logic [3:0]  io_be_o;
  logic [31:0] io_rdata_i;
  logic        io_ready_i;

  logic        both_sel;
  logic        rand_data;
  int          n_checks;
  int          n_errors;

  mem_bus_router #(.RAM_LATENCY(TB_RL), .IO_TIMEOUT(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_be_i(cpu_be_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o),
    .dec_addr_o(dec_addr_o), .ram_select_i(ram_select_i), .io_select_i(io_select_i),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i),
    .io_req_o(io_req_o), .io_we_o(io_we_o), .io_addr_o(io_addr_o),
    .io_wdata_o(io_wdata_o), .io_be_o(io_be_o), .io_rdata_i(io_rdata_i),
    .io_ready_i(io_ready_i)
  );

  // Address decoder: top nibble 0 is RAM, 0xF is IO, anything else unmapped
  assign ram_select_i = (dec_addr_o[29:26] == 4'h0) | both_sel;
  assign io_select_i  = (dec_addr_o[29:26] == 4'hF) | both_sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Timeline model: per accepted request, derive which cycle carries each command and the ack
  initial begin : model
    int          cyc;
    bit          busy;
    int          t0;
    int          ta;
    int          kind;
    bit          io_end;
    logic        m_we;
    logic [29:0] m_addr;
    logic [31:0] m_wd;
    logic [3:0]  m_be;
    logic [31:0] m_rd;
    logic        m_err;
    bit          e_ack;
    bit          e_ram;
    bit          e_io;
    logic [29:0] e_dec;
    busy = 0; t0 = 0; ta = -1; kind = 0; io_end = 0;
    m_we = 0; m_addr = '0; m_wd = '0; m_be = '0; m_rd = '0; m_err = 0;
    @(posedge clk);
    cyc = 1;
    forever begin
      @(negedge clk);
      if (busy && ta >= 0 && cyc > ta) busy = 0;
      e_ack = busy && (ta == cyc);
      e_ram = busy && (kind == 1) && (cyc == t0 + 1);
      e_io  = busy && (kind == 2) && (cyc > t0) && !io_end;
      e_dec = busy ? m_addr : cpu_addr_i;
      chk("ack", 32'(cpu_ack_o), 32'(e_ack));
      chk("err", 32'(cpu_err_o), e_ack ? 32'(m_err) : 32'h0);
      chk("rdata", cpu_rdata_o, e_ack ? m_rd : 32'h0);
      chk("ram_req", 32'(ram_req_o), 32'(e_ram));
      chk("io_req", 32'(io_req_o), 32'(e_io));
      chk("dec_addr", 32'(dec_addr_o), 32'(e_dec));
      if (e_ram) begin
        chk("ram_we", 32'(ram_we_o), 32'(m_we));
        chk("ram_addr", 32'(ram_addr_o), 32'(m_addr[25:0]));
        chk("ram_wdata", ram_wdata_o, m_wd);
        chk("ram_be", 32'(ram_be_o), 32'(m_be));
      end
      if (e_io) begin
        chk("io_we", 32'(io_we_o), 32'(m_we));
        chk("io_addr", 32'(io_addr_o), 32'(m_addr[13:0]));
        chk("io_wdata", io_wdata_o, m_wd);
        chk("io_be", 32'(io_be_o), 32'(m_be));
      end
      if (busy) begin
        if (kind == 1 && !m_we && cyc == t0 + 1 + TB_RL) m_rd = ram_rdata_i;
        if (kind == 2 && !io_end && cyc > t0) begin
          if (io_ready_i) begin
            io_end = 1; ta = cyc + 1; m_err = 0; m_rd = m_we ? 32'h0 : io_rdata_i;
          end else if (cyc == t0 + TB_TO) begin
            io_end = 1; ta = cyc + 1; m_err = 1; m_rd = 32'h0;
          end
        end
      end else if (cpu_req_i && !rst) begin
        busy = 1; t0 = cyc; m_we = cpu_we_i; m_addr = cpu_addr_i;
        m_wd = cpu_wdata_i; m_be = cpu_be_i; m_rd = 32'h0; m_err = 0; io_end = 0;
        kind = ram_select_i ? 1 : (io_select_i ? 2 : 0);
        if (kind == 0) begin
          ta = cyc + 1; m_err = 1;
        end else if (kind == 1) begin
          ta = m_we ? cyc + 2 : cyc + 2 + TB_RL;
        end else begin
          ta = -1;
        end
      end
      if (rst) busy = 0;
      cyc++;
    end
  end

  // Presents one request (called at #1 after a rising edge) and holds it until the ack.
  // rdy_at >= 0 pulses ready on that relative cycle; otherwise ready is random with rdy_pct.
  task automatic run_txn(input logic we, input logic [29:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int rdy_at, input int rdy_pct,
                         output int lat, output logic [31:0] rd, output logic er,
                         output int nr, output int ni);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd; cpu_be_i = be;
    lat = -1; rd = '0; er = 1'b0; nr = 0; ni = 0;
    for (int c = 0; c < TB_TO + TB_RL + 8; c++) begin
      io_ready_i = (rdy_at >= 0) ? (c == rdy_at) : (int'($urandom_range(99)) < rdy_pct);
      if (rand_data) begin
        ram_rdata_i = $urandom;
        io_rdata_i  = $urandom;
      end
      @(negedge clk);
      nr += int'(ram_req_o);
      ni += int'(io_req_o);
      if (cpu_ack_o) begin
        lat = c; rd = cpu_rdata_o; er = cpu_err_o;
      end
      @(posedge clk); #1;
      if (lat >= 0) break;
    end
    chk("ack_seen", 32'(lat >= 0), 32'h1);
    cpu_req_i  = 1'b0;
    io_ready_i = 1'b0;
  endtask

  task automatic idle(input int n);
    cpu_req_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      io_ready_i = 1'($urandom_range(1));
      cpu_addr_i = 30'($urandom);
      @(posedge clk); #1;
    end
    io_ready_i = 1'b0;
  endtask

  initial begin : stim
    int          lat;
    int          nr;
    int          ni;
    int          act;
    int          cls;
    int          pct;
    logic [31:0] rd;
    logic        er;
    logic [29:0] a;
    n_checks = 0; n_errors = 0;
    both_sel = 0; rand_data = 0;
    rst = 1'b1;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 30'h0000123;
    cpu_wdata_i = '0; cpu_be_i = 4'hF;
    ram_rdata_i = 32'hDEADBEEF; io_rdata_i = '0; io_ready_i = 1'b0;

    // Reset held three edges with a request pending: nothing may issue
    @(posedge clk); #1;
    act = 0;
    repeat (2) begin
      @(negedge clk);
      act += int'(ram_req_o) + int'(io_req_o) + int'(cpu_ack_o);
      @(posedge clk); #1;
    end
    chk("reset_quiet", 32'(act), 32'h0);
    rst = 1'b0;

    run_txn(1'b0, 30'h0000123, 32'h0, 4'hF, -1, 0, lat, rd, er, nr, ni);
    chk("ram_load_lat", 32'(lat), 32'd3);
    chk("ram_load_rdata", rd, 32'hDEADBEEF);
    chk("ram_load_err", 32'(er), 32'h0);
    chk("ram_load_nreq", 32'(nr), 32'd1);
    idle(1);

    run_txn(1'b1, 30'h10, 32'hA5A5A5A5, 4'h3, -1, 0, lat, rd, er, nr, ni);
    chk("ram_store_lat", 32'(lat), 32'd2);
    chk("ram_store_nreq", 32'(nr), 32'd1);
    chk("ram_store_rdata", rd, 32'h0);
    idle(2);

    io_rdata_i = 32'h00000042;
    run_txn(1'b0, 30'h3C000005, 32'h0, 4'hF, 5, 0, lat, rd, er, nr, ni);
    chk("io_load_lat", 32'(lat), 32'd6);
    chk("io_load_rdata", rd, 32'h42);
    chk("io_load_nreq", 32'(ni), 32'd5);
    idle(1);

    run_txn(1'b0, 30'h3C000010, 32'h0, 4'hF, -1, 0, lat, rd, er, nr, ni);
    chk("io_timeout_lat", 32'(lat), 32'd9);
    chk("io_timeout_err", 32'(er), 32'h1);
    chk("io_timeout_rdata", rd, 32'h0);
    chk("io_timeout_nreq", 32'(ni), 32'd8);
    idle(1);

    io_rdata_i = 32'h0BADF00D;
    run_txn(1'b0, 30'h3C000011, 32'h0, 4'hF, TB_TO, 0, lat, rd, er, nr, ni);
    chk("io_last_ready_lat", 32'(lat), 32'd9);
    chk("io_last_ready_err", 32'(er), 32'h0);
    chk("io_last_ready_rdata", rd, 32'h0BADF00D);
    idle(1);

    run_txn(1'b1, 30'h3C000012, 32'h11223344, 4'h1, 1, 0, lat, rd, er, nr, ni);
    chk("io_store_min_lat", 32'(lat), 32'd2);
    chk("io_store_rdata", rd, 32'h0);
    idle(1);

    run_txn(1'b0, 30'h20000000, 32'h0, 4'hF, -1, 0, lat, rd, er, nr, ni);
    chk("unmapped_lat", 32'(lat), 32'd1);
    chk("unmapped_err", 32'(er), 32'h1);
    chk("unmapped_nreq", 32'(nr + ni), 32'h0);
    ram_rdata_i = 32'h12345678;
    run_txn(1'b0, 30'h0000200, 32'h0, 4'hF, -1, 0, lat, rd, er, nr, ni);
    chk("b2b_ram_lat", 32'(lat), 32'd3);
    chk("b2b_ram_rdata", rd, 32'h12345678);
    idle(1);

    both_sel = 1'b1;
    run_txn(1'b1, 30'h3C000001, 32'hCAFE0001, 4'hC, -1, 0, lat, rd, er, nr, ni);
    both_sel = 1'b0;
    chk("both_sel_ram_nreq", 32'(nr), 32'd1);
    chk("both_sel_io_nreq", 32'(ni), 32'd0);
    idle(1);

    // Reset in the middle of an IO wait abandons it
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 30'h3C000020; io_ready_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; cpu_req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    act = 0;
    repeat (4) begin
      @(negedge clk);
      act += int'(ram_req_o) + int'(io_req_o) + int'(cpu_ack_o);
      @(posedge clk); #1;
    end
    chk("reset_abort", 32'(act), 32'h0);

    rand_data = 1'b1;
    for (int n = 0; n < 200; n++) begin
      cls = int'($urandom_range(7));
      a = 30'($urandom);
      a[29:26] = (cls < 3) ? 4'h0 : (cls < 6) ? 4'hF : (cls == 6) ? 4'h5 : 4'h0;
      both_sel = (cls == 7);
      case ($urandom_range(3))
        0: pct = 0;
        1: pct = 10;
        2: pct = 40;
        default: pct = 100;
      endcase
      run_txn(1'($urandom_range(1)), a, $urandom, 4'($urandom), -1, pct,
              lat, rd, er, nr, ni);
      both_sel = 1'b0;
      idle(int'($urandom_range(2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
